timer_counter_n: RTL and testbench
==================================

Name: timer_counter_n

Overview:
- Parametrised successor to the fixed 8-bit timer counter.
- WIDTH-bit up/down timer counter with load, clock-enable tick qualifier and sticky overflow/underflow flags.
- New capabilities: auto-reload on wrap, one-shot mode with a run/done state machine, and an optional compare-match flag.
- Sits between the register interface (start value, mode and control bits) and the interrupt/flag logic of the timer block.

Parameters:
- WIDTH, 8: counter, start value and compare width (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clk_ena  in  1  count tick from the prescaler; the counter advances only on cycles where it is 1.
- enable  in  1  run enable.
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  load start_counter into the counter.
- start_counter  in  WIDTH  load and reload value.
- one_shot  in  1  1 = stop after the first wrap; 0 = periodic.
- clr_overflow  in  1  clear the overflow flag.
- clr_underflow  in  1  clear the underflow flag.
- tcnt  out  WIDTH  current count (registered).
- overflow  out  1  sticky up-wrap flag.
- underflow  out  1  sticky down-wrap flag.
- running  out  1  1 when the FSM is in RUN.

Behaviour:
- Reset (rst_n = 0 at a rising clk edge): tcnt = 0, overflow = 0, underflow = 0, running = 0, FSM = IDLE. Reset has priority over every other input, including mid-count.
- FSM states:
  - IDLE -> RUN when enable = 1.
  - RUN -> IDLE when enable = 0.
  - RUN -> DONE on a wrap while one_shot = 1.
  - DONE -> IDLE when enable = 0.
  - DONE -> RUN on load = 1 with enable = 1.
- running = (state == RUN), registered.
- Priority per edge: rst_n, then load, then count.
- load = 1: tcnt <= start_counter on the next edge, independent of clk_ena and state. No flag change.
- Count step: occurs only when state == RUN, enable = 1, clk_ena = 1 and load = 0.
  - Up: tcnt + 1. Down: tcnt - 1.
  - Arithmetic is modulo 2^WIDTH internally.
- Up wrap (tcnt == 2^WIDTH - 1 with up_down = 1): tcnt <= start_counter (auto-reload) and overflow <= 1.
- Down wrap (tcnt == 0 with up_down = 0): tcnt <= start_counter and underflow <= 1.
- Wrap with one_shot = 1: reload and flag as above, and FSM goes to DONE. No further counting until load or an enable toggle.
- Flag clear: clr_x = 1 clears the flag on the next edge.
  - If a set event and clr_x occur on the same edge, set wins (flag = 1).
  - Flags are independent of each other.
- up_down may change between ticks; it takes effect on the next tick, with no glitch or skipped count.
- Flags change only on wrap, clear, or reset. Disable and load do not affect them.
- Latency: tcnt and flags update one clk edge after the qualifying inputs. Outputs are registered and free of combinational paths from inputs.

Optional Feature:
- Macro: TIMER_COMPARE_EN.
- When defined, three ports are added:
  - compare  in  WIDTH  compare value.
  - clr_cmp  in  1  clear the match flag.
  - cmp_match  out  1  sticky match flag.
- cmp_match <= 1 on the edge where a count step produces tcnt == compare. Loads and reloads do not trigger a match.
- Set wins over clr_cmp on the same edge. Reset value of cmp_match is 0.
- When the macro is undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 for 5 clk, release -> tcnt = 0, overflow = 0, underflow = 0, running = 0.
- Periodic up wrap (WIDTH = 8): load start_counter = 8'hFD, enable = 1, clk_ena = 1, up_down = 1.
  - Expect tcnt sequence FE, FF, FD; overflow = 1 on the edge reloading FD; running stays 1.
  - Then clr_overflow = 1 for one cycle -> overflow = 0.
- One-shot down: start_counter = 2, one_shot = 1, up_down = 0.
  - Expect tcnt 1, 0, then reload to 2; underflow = 1; running = 0 (DONE).
  - Further ticks leave tcnt = 2.
- Tick gating and priority:
  - clk_ena = 1 every 4th cycle -> tcnt advances once per 4 clk.
  - load = 1 on a tick cycle with start_counter = 8'h10 -> tcnt = 8'h10, no increment.
- Simultaneous set/clear and reset mid-run:
  - clr_overflow = 1 on the wrap edge -> overflow = 1.
  - rst_n = 0 while counting at 8'h42 -> all outputs 0 on the next edge.
- TIMER_COMPARE_EN defined: compare = 8'h05, count up from 0 -> cmp_match = 1 on the edge tcnt becomes 05.
  - clr_cmp clears it; reloading to 05 via load does not set it.

Source files
------------

// File: rtl/timer_counter_n.sv
// ---------------------------------------------------------------------------
// timer_counter_n
//   WIDTH-bit up/down timer counter with synchronous load, tick qualifier,
//   auto-reload on wrap, sticky overflow/underflow flags and a one-shot
//   run/done state machine.
//
//   Optional macro TIMER_COMPARE_EN adds a sticky compare-match flag
//   (ports compare, clr_cmp, cmp_match).
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   clk_ena        prescaler tick; counting happens only when high
//   enable         run enable
//   up_down        1 = count up, 0 = count down
//   load           load start_counter into tcnt (beats counting)
//   start_counter  load / auto-reload value
//   one_shot       1 = stop (DONE) after the first wrap
//   clr_overflow   clear overflow flag (a same-edge set wins)
//   clr_underflow  clear underflow flag (a same-edge set wins)
//   tcnt           current count
//   overflow       sticky up-wrap flag
//   underflow      sticky down-wrap flag
//   running        high while the FSM is in RUN
//   compare        (TIMER_COMPARE_EN) match value
//   clr_cmp        (TIMER_COMPARE_EN) clear match flag
//   cmp_match      (TIMER_COMPARE_EN) sticky match flag
// ---------------------------------------------------------------------------
module timer_counter_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_ena,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] start_counter,
    input  logic             one_shot,
    input  logic             clr_overflow,
    input  logic             clr_underflow,
`ifdef TIMER_COMPARE_EN
    input  logic [WIDTH-1:0] compare,
    input  logic             clr_cmp,
    output logic             cmp_match,
`endif
    output logic [WIDTH-1:0] tcnt,
    output logic             overflow,
    output logic             underflow,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state, state_next;
    logic             step, wrap_up, wrap_dn, wrap;
    logic [WIDTH-1:0] cnt_step;

    // A count step needs RUN, enable and a tick; a load on the same edge wins.
    assign step     = (state == RUN) && enable && clk_ena && !load;
    assign wrap_up  = step &&  up_down && (tcnt == CNT_MAX);
    assign wrap_dn  = step && !up_down && (tcnt == '0);
    assign wrap     = wrap_up || wrap_dn;
    assign cnt_step = up_down ? (tcnt + CNT_ONE) : (tcnt - CNT_ONE);

    // running is decoded straight from the state flop, so it carries no
    // combinational path from any input.
    assign running  = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN: begin
                if (!enable)              state_next = IDLE;
                else if (wrap && one_shot) state_next = DONE;
            end
            DONE: begin
                if (!enable)   state_next = IDLE;
                else if (load) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter and sticky flags. A wrap reloads start_counter instead of
    // rolling over; flags are set-dominant over their clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (load)      tcnt <= start_counter;
            else if (wrap) tcnt <= start_counter;
            else if (step) tcnt <= cnt_step;

            overflow  <= wrap_up || (overflow  && !clr_overflow);
            underflow <= wrap_dn || (underflow && !clr_underflow);
        end
    end

`ifdef TIMER_COMPARE_EN
    // Only a genuine count step can match; loads and wrap reloads cannot.
    logic cmp_hit;
    assign cmp_hit = step && !wrap && (cnt_step == compare);

    always_ff @(posedge clk) begin
        if (!rst_n) cmp_match <= 1'b0;
        else        cmp_match <= cmp_hit || (cmp_match && !clr_cmp);
    end
`endif

endmodule

// File: tb/tb_timer_counter_n.sv
// ---------------------------------------------------------------------------
// tb_timer_counter_n
//   Directed bench for timer_counter_n (WIDTH = 8). Inputs change #1 after
//   a rising edge and outputs are sampled at that same point, i.e. well
//   clear of the next active edge.
// ---------------------------------------------------------------------------
module tb_timer_counter_n;

    logic       clk = 1'b0;
    logic       rst_n, clk_ena, enable, up_down, load, one_shot;
    logic       clr_overflow, clr_underflow;
    logic [7:0] start_counter;
    logic [7:0] tcnt;
    logic       overflow, underflow, running;
`ifdef TIMER_COMPARE_EN
    logic [7:0] compare;
    logic       clr_cmp, cmp_match;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_counter_n #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_ena       (clk_ena),
        .enable        (enable),
        .up_down       (up_down),
        .load          (load),
        .start_counter (start_counter),
        .one_shot      (one_shot),
        .clr_overflow  (clr_overflow),
        .clr_underflow (clr_underflow),
`ifdef TIMER_COMPARE_EN
        .compare       (compare),
        .clr_cmp       (clr_cmp),
        .cmp_match     (cmp_match),
`endif
        .tcnt          (tcnt),
        .overflow      (overflow),
        .underflow     (underflow),
        .running       (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_ena = 1'b1; enable = 1'b1; up_down = 1'b1; load = 1'b0;
        one_shot = 1'b0; clr_overflow = 1'b0; clr_underflow = 1'b0;
        start_counter = 8'h00;
`ifdef TIMER_COMPARE_EN
        compare = 8'h05; clr_cmp = 1'b0;
`endif
        repeat (5) tick();
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();
        checks++; if (tcnt !== 8'h00) begin errors++; $display("FAIL reset_tcnt got %h exp 00", tcnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_udf got %b exp 0", underflow); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'hFD;
        // Load edge also moves IDLE -> RUN; the load blocks the count.
        load = 1'b1; start_counter = 8'hFD; enable = 1'b1; clk_ena = 1'b1; up_down = 1'b1;
        tick();
        checks++; if (tcnt !== 8'hFD) begin errors++; $display("FAIL upwrap_load got %h exp FD", tcnt); end
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tcnt !== exp_seq[i]) begin errors++; $display("FAIL upwrap_seq%0d got %h exp %h", i, tcnt, exp_seq[i]); end
            checks++; if (overflow !== (i == 2)) begin errors++; $display("FAIL upwrap_ovf%0d got %b exp %b", i, overflow, (i == 2)); end
            checks++; if (running !== 1'b1) begin errors++; $display("FAIL upwrap_running%0d got %b exp 1", i, running); end
        end
        clk_ena = 1'b0; clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL upwrap_clr got %b exp 0", overflow); end
        checks++; if (tcnt !== 8'hFD) begin errors++; $display("FAIL upwrap_hold got %h exp FD", tcnt); end
    endtask

    task automatic test_one_shot_down();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h00; exp_seq[2] = 8'h02;
        load = 1'b1; start_counter = 8'h02; one_shot = 1'b1; up_down = 1'b0; clk_ena = 1'b0;
        tick();
        load = 1'b0; clk_ena = 1'b1;
        checks++; if (tcnt !== 8'h02) begin errors++; $display("FAIL oneshot_load got %h exp 02", tcnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tcnt !== exp_seq[i]) begin errors++; $display("FAIL oneshot_seq%0d got %h exp %h", i, tcnt, exp_seq[i]); end
        end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL oneshot_udf got %b exp 1", underflow); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oneshot_ovf got %b exp 0", overflow); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL oneshot_done got %b exp 0", running); end
        repeat (3) tick();
        checks++; if (tcnt !== 8'h02) begin errors++; $display("FAIL oneshot_stopped got %h exp 02", tcnt); end
        clr_underflow = 1'b1;
        tick();
        clr_underflow = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL oneshot_udfclr got %b exp 0", underflow); end
        // Load with enable re-arms DONE -> RUN; counting resumes down.
        load = 1'b1; start_counter = 8'h07;
        tick();
        load = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL oneshot_rearm got %b exp 1", running); end
        tick();
        checks++; if (tcnt !== 8'h06) begin errors++; $display("FAIL oneshot_resume got %h exp 06", tcnt); end
        enable = 1'b0; one_shot = 1'b0;
        tick();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL disable_idle got %b exp 0", running); end
        tick();
        checks++; if (tcnt !== 8'h06) begin errors++; $display("FAIL disable_hold got %h exp 06", tcnt); end
    endtask

    task automatic test_tick_gating();
        logic [7:0] exp;
        load = 1'b1; start_counter = 8'h20; enable = 1'b1; up_down = 1'b1; clk_ena = 1'b0;
        tick();
        load = 1'b0;
        exp = 8'h20;
        for (int i = 0; i < 8; i++) begin
            clk_ena = (i % 4 == 0);
            tick();
            if (i % 4 == 0) exp = exp + 8'h01;
            checks++; if (tcnt !== exp) begin errors++; $display("FAIL gate_cyc%0d got %h exp %h", i, tcnt, exp); end
        end
        // up_down flip between ticks: next tick counts down.
        clk_ena = 1'b1; up_down = 1'b0;
        tick();
        checks++; if (tcnt !== 8'h21) begin errors++; $display("FAIL dirflip got %h exp 21", tcnt); end
        up_down = 1'b1; load = 1'b1; start_counter = 8'h10;
        tick();
        load = 1'b0; clk_ena = 1'b0;
        checks++; if (tcnt !== 8'h10) begin errors++; $display("FAIL load_prio got %h exp 10", tcnt); end
        tick();
        checks++; if (tcnt !== 8'h10) begin errors++; $display("FAIL load_noinc got %h exp 10", tcnt); end
    endtask

    task automatic test_set_clear_reset();
        load = 1'b1; start_counter = 8'hFF;
        tick();
        load = 1'b0; clk_ena = 1'b1; clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0; clk_ena = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL setwins got %b exp 1", overflow); end
        checks++; if (tcnt !== 8'hFF) begin errors++; $display("FAIL setwins_reload got %h exp FF", tcnt); end
        // Leave a down-wrap pending too so reset has two flags to clear.
        load = 1'b1; start_counter = 8'h00;
        tick();
        load = 1'b0; up_down = 1'b0; clk_ena = 1'b1; start_counter = 8'h41;
        tick();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got %b exp 1", underflow); end
        up_down = 1'b1;
        tick();
        checks++; if (tcnt !== 8'h42) begin errors++; $display("FAIL pre_reset got %h exp 42", tcnt); end
        rst_n = 1'b0;
        tick();
        checks++; if ({tcnt, overflow, underflow, running} !== 11'h0) begin
            errors++; $display("FAIL midrun_reset got %h/%b/%b/%b exp 00/0/0/0", tcnt, overflow, underflow, running);
        end
        rst_n = 1'b1; clk_ena = 1'b0; enable = 1'b0;
        tick();
    endtask

`ifdef TIMER_COMPARE_EN
    task automatic test_compare();
        compare = 8'h05; enable = 1'b1; up_down = 1'b1; load = 1'b1; start_counter = 8'h00;
        tick();
        load = 1'b0; clk_ena = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (cmp_match !== (i == 5)) begin errors++; $display("FAIL cmp_step%0d got %b exp %b", i, cmp_match, (i == 5)); end
        end
        clk_ena = 1'b0; clr_cmp = 1'b1;
        tick();
        clr_cmp = 1'b0;
        checks++; if (cmp_match !== 1'b0) begin errors++; $display("FAIL cmp_clr got %b exp 0", cmp_match); end
        load = 1'b1; start_counter = 8'h05;
        tick();
        load = 1'b0;
        checks++; if (cmp_match !== 1'b0) begin errors++; $display("FAIL cmp_load got %b exp 0", cmp_match); end
        checks++; if (tcnt !== 8'h05) begin errors++; $display("FAIL cmp_loadval got %h exp 05", tcnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_one_shot_down();
        test_tick_gating();
        test_set_clear_reset();
`ifdef TIMER_COMPARE_EN
        test_compare();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
